// File: rtl/mips_define.sv
// rtl/mips_define.sv - shared MIPS EXE/CP0 codes, register numbers and bit positions
package mips_define;

  // Coprocessor operation codes issued by the decode controller
  localparam logic [1:0] EXE_CP_NONE  = 2'd0;
  localparam logic [1:0] EXE_CP_STORE = 2'd1;
  localparam logic [1:0] EXE_CP_ERET  = 2'd2;
  localparam logic [1:0] EXE_CP_RSVD  = 2'd3;

  // CP0 register numbers
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_EHBR  = 5'd15;

  // Architectural bit positions
  localparam int SR_IE     = 0;
  localparam int CAUSE_IP2 = 10;

  // Redirect sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REDIR = 2'd1,
    ST_FLUSH = 2'd2
  } cp0_state_t;

endpackage

// File: rtl/cp0_unit_sync_edge.sv
// rtl/cp0_unit_sync_edge.sv - N-stage synchroniser with rising-edge pulse
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  // Shift the asynchronous input through the synchroniser and keep one
  // extra flop of history so a held level produces a single pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - MIPS coprocessor 0: status/cause/EPC/handler base and PC redirect
module cp0_unit
  import mips_define::*;
#(
  parameter logic [31:0] HANDLER_RST  = 32'h0000_0008,
  parameter int          SYNC_STAGES  = 2,
  parameter int          FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  oper,
  input  logic [4:0]  addr_r,
  output logic [31:0] data_r,
  input  logic [4:0]  addr_w,
  input  logic [31:0] data_w,
  input  logic [31:0] ret_addr,
  input  logic        ret_valid,
  input  logic        ir_in,
  output logic        jump_en,
  output logic [31:0] jump_addr,
  output logic        int_pending
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  cp0_state_t       state;
  logic [CNT_W-1:0] flush_cnt;
  logic             sr_ie;
  logic [31:0]      epc;
  logic [31:2]      ehbr;
  logic             pending;
  logic             ir_rise;

  logic             in_idle;
  logic             do_eret;
  logic             do_store;
  logic             do_irq;

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (ir_in),
    .rise (ir_rise)
  );

  // Decode this cycle's action; ERET beats MTC0, which beats interrupt entry.
  // Only NONE (and the reserved code, treated as NONE) leaves room for an interrupt.
  always_comb begin
    in_idle  = (state == ST_IDLE);
    do_eret  = in_idle & en & (oper == EXE_CP_ERET);
    do_store = in_idle & en & (oper == EXE_CP_STORE);
    do_irq   = in_idle & en & ((oper == EXE_CP_NONE) | (oper == EXE_CP_RSVD))
             & pending & sr_ie & ret_valid;
  end

  // Redirect sequencer: one-cycle jump pulse, then a flush window with interrupts held off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
      jump_en   <= 1'b0;
      jump_addr <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          jump_en <= 1'b0;
          if (do_eret) begin
            jump_en   <= 1'b1;
            jump_addr <= epc;
            state     <= ST_REDIR;
          end else if (do_irq) begin
            jump_en   <= 1'b1;
            jump_addr <= {ehbr, 2'b00};
            state     <= ST_REDIR;
          end
        end
        ST_REDIR: begin
          jump_en   <= 1'b0;
          flush_cnt <= CNT_LOAD;
          state     <= ST_FLUSH;
        end
        ST_FLUSH: begin
          jump_en <= 1'b0;
          if (flush_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        default: begin
          jump_en <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Architectural registers; CAUSE has no storage of its own, it mirrors pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_ie <= 1'b0;
      epc   <= 32'h0;
      ehbr  <= HANDLER_RST[31:2];
    end else if (do_eret) begin
      sr_ie <= 1'b1;
    end else if (do_store) begin
      case (addr_w)
        CP0_SR:   sr_ie <= data_w[SR_IE];
        CP0_EPC:  epc   <= data_w;
        CP0_EHBR: ehbr  <= data_w[31:2];
        default:  ;
      endcase
    end else if (do_irq) begin
      sr_ie <= 1'b0;
      epc   <= ret_addr;
    end
  end

  // Latched interrupt request: armed by each synchronised rising edge, cleared on entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else begin
      pending <= (pending & ~do_irq) | ir_rise;
    end
  end

  // MFC0 read port; reads see register contents before any same-cycle write
  always_comb begin
    data_r = 32'h0;
    case (addr_r)
      CP0_SR:    data_r[SR_IE]     = sr_ie;
      CP0_CAUSE: data_r[CAUSE_IP2] = pending;
      CP0_EPC:   data_r            = epc;
      CP0_EHBR:  data_r            = {ehbr, 2'b00};
      default:   data_r            = 32'h0;
    endcase
  end

  assign int_pending = pending;

endmodule
